// File: rtl/nrdiv_seq_if.sv
// nrdiv_seq_if: handshake and data bundle for the nrdiv_seq divider.
//   master : issue side (drives operands and out_ready, observes results)
//   slave  : divider side
// Signals:
//   in_valid/in_ready    operand handshake
//   dividend/divisor     W-bit unsigned operands
//   out_valid/out_ready  result handshake
//   quotient/remainder   W-bit unsigned results
//   div_zero             divisor was zero for the presented result
//   busy                 divider is iterating (RUN or FIX)
interface nrdiv_seq_if #(
   parameter int unsigned W = 80
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_zero;
   logic         busy;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_zero, busy
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_zero, busy
   );
endinterface

// File: rtl/nrdiv_seq.sv
// nrdiv_seq: sequential unsigned non-restoring divider, one operation in flight.
// The sign of the previous partial remainder selects add or subtract each
// iteration; W iterations, then one remainder-correction cycle.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    nrdiv_seq_if.slave (operand/result handshakes, div_zero, busy)
// Parameters:
//   W   operand/result width (W >= 2)
//   CW  iteration counter width (2**CW > W)
// Optional build macro NRDIV_ZERO_BYPASS_EN: a zero divisor skips the
// iterations and presents {all ones, dividend} one edge after capture.
module nrdiv_seq #(
   parameter int unsigned W  = 80,
   parameter int unsigned CW = 7
) (
   input logic        clk,
   input logic        rst_n,
   nrdiv_seq_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t          state, state_nx;
   logic [W:0]      r, r_nx;        // signed partial remainder
   logic [W-1:0]    q, q_nx;
   logic [W-1:0]    d, d_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic [W-1:0]    quo, quo_nx;
   logic [W-1:0]    rem, rem_nx;
   logic            dz, dz_nx;

   logic [W:0]      r_sh;
   logic [W:0]      r_it;
   logic [W:0]      r_fix;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         r     <= '0;
         q     <= '0;
         d     <= '0;
         cnt   <= '0;
         quo   <= '0;
         rem   <= '0;
         dz    <= 1'b0;
      end else begin
         state <= state_nx;
         r     <= r_nx;
         q     <= q_nx;
         d     <= d_nx;
         cnt   <= cnt_nx;
         quo   <= quo_nx;
         rem   <= rem_nx;
         dz    <= dz_nx;
      end
   end

   always_comb begin
      state_nx = state;
      r_nx     = r;
      q_nx     = q;
      d_nx     = d;
      cnt_nx   = cnt;
      quo_nx   = quo;
      rem_nx   = rem;
      dz_nx    = dz;

      // shift {R,Q} left, then subtract D when R was non-negative, else add
      r_sh  = {r[W-1:0], q[W-1]};
      r_it  = r[W] ? (r_sh + {1'b0, d}) : (r_sh - {1'b0, d});
      r_fix = r[W] ? (r + {1'b0, d}) : r;

      unique case (state)
         IDLE: begin
            if (bus.in_valid) begin
               d_nx     = bus.divisor;
               q_nx     = bus.dividend;
               r_nx     = '0;
               cnt_nx   = '0;
               dz_nx    = (bus.divisor == '0);
               state_nx = RUN;
`ifdef NRDIV_ZERO_BYPASS_EN
               // Preload the final iteration state so FIX emits
               // {all ones, dividend} on the very next edge.
               if (bus.divisor == '0) begin
                  q_nx     = '1;
                  r_nx     = {1'b0, bus.dividend};
                  state_nx = FIX;
               end
`endif
            end
         end
         RUN: begin
            r_nx   = r_it;
            q_nx   = {q[W-2:0], ~r_it[W]};
            cnt_nx = cnt + 1'b1;
            if (cnt == CW'(W - 1)) begin
               state_nx = FIX;
            end
         end
         FIX: begin
            r_nx     = r_fix;
            quo_nx   = q;
            rem_nx   = r_fix[W-1:0];
            state_nx = DONE;
         end
         DONE: begin
            if (bus.out_ready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.busy      = (state == RUN) || (state == FIX);
   assign bus.quotient  = quo;
   assign bus.remainder = rem;
   assign bus.div_zero  = dz;

endmodule

// File: tb/tb_nrdiv_seq.sv
// tb_nrdiv_seq: directed and randomized checks of nrdiv_seq at W=80.
module tb_nrdiv_seq;

   localparam int unsigned W = 80;
`ifdef NRDIV_ZERO_BYPASS_EN
   localparam int ZLAT = 1;
`else
   localparam int ZLAT = W + 1;
`endif
   localparam int LAT = W + 1;

   logic clk;
   logic rst_n;

   nrdiv_seq_if #(.W(W)) bus ();

   nrdiv_seq #(.W(W), .CW(7)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_chk;
   int unsigned n_pass;

   task automatic check(input string tag, input logic [191:0] act, input logic [191:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   function automatic logic [W-1:0] rnd80();
      logic [95:0] t;
      t = {$urandom, $urandom, $urandom};
      return t[W-1:0];
   endfunction

   // Present one operand pair and wait (bounded) for out_valid.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
      int guard;
      guard = 0;
      while (!bus.in_ready && guard < 300) begin
         @(posedge clk); #1;
         guard++;
      end
      bus.dividend = a;
      bus.divisor  = b;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.dividend = rnd80();
      bus.divisor  = rnd80();
      lat = 0;
      while (!bus.out_valid && lat < 300) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic accept();
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_in_ready"},  192'(bus.in_ready),  192'(1));
      check({tag, "_out_valid"}, 192'(bus.out_valid), 192'(0));
      check({tag, "_busy"},      192'(bus.busy),      192'(0));
      check({tag, "_div_zero"},  192'(bus.div_zero),  192'(0));
      check({tag, "_quotient"},  192'(bus.quotient),  192'(0));
      check({tag, "_remainder"}, 192'(bus.remainder), 192'(0));
   endtask

   task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic edz, input int elat);
      int lat;
      run_op(a, b, lat);
      check({tag, "_lat"}, 192'(lat),           192'(elat));
      check({tag, "_q"},   192'(bus.quotient),  192'(eq));
      check({tag, "_r"},   192'(bus.remainder), 192'(er));
      check({tag, "_dz"},  192'(bus.div_zero),  192'(edz));
      accept();
      check({tag, "_ov_drop"}, 192'(bus.out_valid), 192'(0));
   endtask

   initial begin
      logic [W-1:0] ones;
      logic [W-1:0] a, b;
      logic [191:0] prod;
      int lat;
      int ov_seen;

      n_chk = 0;
      n_pass = 0;
      ones = '1;
      rst_n = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;

      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("rst");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic division with exact latency, busy/in_ready during RUN
      bus.dividend = 80'd100;
      bus.divisor  = 80'd7;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("run_busy",     192'(bus.busy),     192'(1));
      check("run_in_ready", 192'(bus.in_ready), 192'(0));
      lat = 0;
      while (!bus.out_valid && lat < 300) begin
         @(posedge clk); #1;
         lat++;
      end
      check("d100_lat", 192'(lat),           192'(LAT));
      check("d100_q",   192'(bus.quotient),  192'(14));
      check("d100_r",   192'(bus.remainder), 192'(2));
      check("d100_dz",  192'(bus.div_zero),  192'(0));
      check("d100_busy",192'(bus.busy),      192'(0));
      accept();

      directed("max_by_1", ones, 80'd1, ones, 80'd0, 1'b0, LAT);
      directed("5_by_2p79", 80'd5, {1'b1, 79'd0}, 80'd0, 80'd5, 1'b0, LAT);
      directed("div0", 80'h1234, 80'd0, ones, 80'h1234, 1'b1, ZLAT);
      directed("eq", 80'd77, 80'd77, 80'd1, 80'd0, 1'b0, LAT);
      directed("lt", 80'd6, 80'd7, 80'd0, 80'd6, 1'b0, LAT);

      // Back-pressure: hold result 10 cycles with a competing in_valid
      run_op(80'd12, 80'd5, lat);
      check("stall_lat", 192'(lat), 192'(LAT));
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = 1'b1;
         bus.dividend = 80'd999;
         bus.divisor  = 80'd1;
         @(posedge clk); #1;
         check("stall_q",        192'(bus.quotient),  192'(2));
         check("stall_r",        192'(bus.remainder), 192'(2));
         check("stall_out_valid",192'(bus.out_valid), 192'(1));
         check("stall_in_ready", 192'(bus.in_ready),  192'(0));
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      check("acc_out_valid", 192'(bus.out_valid), 192'(0));
      check("acc_in_ready",  192'(bus.in_ready),  192'(1));
      check("acc_no_capture",192'(bus.busy),      192'(0));
      check("acc_q_held",    192'(bus.quotient),  192'(2));
      @(posedge clk); #1;
      check("idle_no_capture", 192'(bus.busy), 192'(0));

      // Reset in the middle of 1000/3
      bus.dividend = 80'd1000;
      bus.divisor  = 80'd3;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_vals("midrst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      ov_seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid) ov_seen++;
      end
      check("midrst_no_ov", 192'(ov_seen), 192'(0));
      directed("after_rst", 80'd9, 80'd3, 80'd3, 80'd0, 1'b0, LAT);

      // Random back-to-back operations with random result stalls
      for (int n = 0; n < 200; n++) begin
         a = rnd80();
         b = rnd80() >> $urandom_range(0, W - 1);
         if (b == '0) b = 80'd1;
         run_op(a, b, lat);
         check("rnd_lat", 192'(lat), 192'(LAT));
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         prod = 192'(bus.quotient) * 192'(b) + 192'(bus.remainder);
         check("rnd_inv",   prod, 192'(a));
         check("rnd_r_lt_d",192'(bus.remainder < b), 192'(1));
         check("rnd_dz",    192'(bus.div_zero), 192'(0));
         accept();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
